// File: rtl/fp_mul_param.sv
// fp_mul_param: parametrised multi-cycle IEEE-754 binary multiplier.
//   Iterative shift-add significand multiply, round-to-nearest-even,
//   gradual underflow, exception flags, valid/ready on both sides.
//   Optional macro FP_MUL_DAZ_EN: subnormal operands read as zero and
//   subnormal results flush to zero (underflow + inexact).
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, op_a, op_b   : operand handshake, {sign, exp, frac}
//   out_valid/out_ready, result     : product handshake
//   flags                           : {invalid, overflow, underflow, inexact}
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int P  = 2*MAN_W + 2;          // product width
  localparam int XW = EXP_W + 2;            // signed working exponent width
  localparam int CW = $clog2(MAN_W + 1);
  localparam logic signed [XW-1:0] BIAS_X    = XW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << EXP_W) - 1);
  // Below this exponent every product bit ends up in sticky, so the
  // outcome is the same; clamping bounds the number of NORM shifts.
  localparam logic signed [XW-1:0] EXP_FLOOR = XW'(-(MAN_W + 2));

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_MUL, S_NORM, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  logic [W-1:0]          r_a, r_b;
  logic                  r_sign;
  logic signed [XW-1:0]  r_exp;
  logic [P-1:0]          r_mcand, r_prod;
  logic [MAN_W:0]        r_mplier;
  logic [CW-1:0]         r_cnt;
  logic                  r_sticky;
  logic [W-1:0]          r_stage_res, r_result;
  logic [3:0]            r_stage_flags, r_flags;

  // ---------------- operand classification ----------------
  logic [EXP_W-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic w_ea_zero, w_eb_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic w_sign, w_special;
  logic [MAN_W:0] w_ma, w_mb;
  logic signed [XW-1:0] w_exp_sum, w_exp_clamped;

  assign w_ea = r_a[W-2:MAN_W];
  assign w_eb = r_b[W-2:MAN_W];
  assign w_fa = r_a[MAN_W-1:0];
  assign w_fb = r_b[MAN_W-1:0];
  assign w_ea_zero = ~|w_ea;
  assign w_eb_zero = ~|w_eb;
  assign w_a_nan = (&w_ea) & (|w_fa);
  assign w_b_nan = (&w_eb) & (|w_fb);
  assign w_a_inf = (&w_ea) & ~(|w_fa);
  assign w_b_inf = (&w_eb) & ~(|w_fb);
`ifdef FP_MUL_DAZ_EN
  assign w_a_zero = w_ea_zero;
  assign w_b_zero = w_eb_zero;
`else
  assign w_a_zero = w_ea_zero & ~(|w_fa);
  assign w_b_zero = w_eb_zero & ~(|w_fb);
`endif
  assign w_sign    = r_a[W-1] ^ r_b[W-1];
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_ma      = {~w_ea_zero, w_fa};
  assign w_mb      = {~w_eb_zero, w_fb};
  // Subnormals carry the same scale as exponent 1.
  assign w_ea_eff  = w_ea_zero ? EXP_W'(1) : w_ea;
  assign w_eb_eff  = w_eb_zero ? EXP_W'(1) : w_eb;
  assign w_exp_sum = $signed({2'b00, w_ea_eff}) + $signed({2'b00, w_eb_eff}) - BIAS_X;
  assign w_exp_clamped = (w_exp_sum < EXP_FLOOR) ? EXP_FLOOR : w_exp_sum;

  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_flags;
  always_comb begin
    w_spec_res   = {w_sign, {(W-1){1'b0}}};
    w_spec_flags = 4'b0000;
    if (w_a_nan) begin
      w_spec_res          = r_a;
      w_spec_res[MAN_W-1] = 1'b1;
      w_spec_flags[3]     = ~w_fa[MAN_W-1];
    end else if (w_b_nan) begin
      w_spec_res          = r_b;
      w_spec_res[MAN_W-1] = 1'b1;
      w_spec_flags[3]     = ~w_fb[MAN_W-1];
    end else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
      w_spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_flags = 4'b1000;
    end else if (w_a_inf | w_b_inf) begin
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // ---------------- normalisation decisions ----------------
  logic w_msb, w_lead, w_norm_rshift, w_norm_lshift, w_norm_done;
  logic signed [XW-1:0] w_exp_inc, w_exp_dec;
  assign w_msb     = r_prod[P-1];
  assign w_lead    = r_prod[2*MAN_W];
  assign w_exp_inc = r_exp + ONE_X;
  assign w_exp_dec = r_exp - ONE_X;
`ifdef FP_MUL_DAZ_EN
  // Operands are normal here, so only the product-overflow shift exists.
  assign w_norm_rshift = w_msb;
  assign w_norm_lshift = 1'b0;
  assign w_norm_done   = 1'b1;
`else
  assign w_norm_rshift = w_msb | (r_exp < ONE_X);
  assign w_norm_lshift = ~w_norm_rshift & ~w_lead & (r_exp > ONE_X);
  // The product-overflow shift finishes in the same cycle so a normal
  // result spends exactly one cycle in NORM.
  assign w_norm_done   = (w_msb & (w_exp_inc >= ONE_X)) | (~w_norm_rshift & ~w_norm_lshift);
`endif

  // ---------------- rounding ----------------
  logic [MAN_W:0]   w_kept;
  logic [MAN_W+1:0] w_rsum;
  logic [MAN_W-1:0] w_frac_r;
  logic w_g, w_r, w_s, w_inexact, w_rup, w_carry, w_lead_r, w_tiny, w_ovf;
  logic signed [XW-1:0] w_exp_r;
  logic [W-1:0] w_rnd_res;
  logic [3:0]   w_rnd_flags;

  assign w_kept    = r_prod[2*MAN_W:MAN_W];
  assign w_g       = r_prod[MAN_W-1];
  assign w_r       = r_prod[MAN_W-2];
  assign w_s       = (|r_prod[MAN_W-3:0]) | r_sticky;
  assign w_inexact = w_g | w_r | w_s;
  assign w_rup     = w_g & (w_r | w_s | w_kept[0]);
  assign w_rsum    = {1'b0, w_kept} + (MAN_W+2)'(w_rup);
  assign w_carry   = w_rsum[MAN_W+1];
  assign w_exp_r   = w_carry ? w_exp_inc : r_exp;
  assign w_frac_r  = w_carry ? w_rsum[MAN_W:1] : w_rsum[MAN_W-1:0];
  // A subnormal that rounds up into bit MAN_W becomes the smallest normal.
  assign w_lead_r  = w_carry | w_rsum[MAN_W];
  assign w_tiny    = (r_exp == ONE_X) & ~w_lead;
  assign w_ovf     = (w_exp_r >= EXP_MAX_X);

  always_comb begin
    w_rnd_res   = {r_sign, (w_lead_r ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac_r};
    w_rnd_flags = {2'b00, w_tiny & w_inexact, w_inexact};
`ifdef FP_MUL_DAZ_EN
    if (r_exp < ONE_X) begin
      w_rnd_res   = {r_sign, {(W-1){1'b0}}};
      w_rnd_flags = 4'b0011;
    end else
`endif
    if (w_ovf) begin
      w_rnd_res   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_flags = 4'b0101;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_next = S_UNPACK;
      S_UNPACK:  w_state_next = w_special ? S_SPECIAL : S_MUL;
      // Special results still pass through PACK, which owns the output write.
      S_SPECIAL: w_state_next = S_PACK;
      S_MUL:     if (r_cnt == CW'(MAN_W)) w_state_next = S_NORM;
      S_NORM:    if (w_norm_done) w_state_next = S_ROUND;
      S_ROUND:   w_state_next = S_PACK;
      S_PACK:    w_state_next = S_DONE;
      S_DONE:    if (out_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_exp <= '0;
      r_mcand <= '0; r_prod <= '0; r_mplier <= '0; r_cnt <= '0; r_sticky <= 1'b0;
      r_stage_res <= '0; r_stage_flags <= '0; r_result <= '0; r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= op_a;
          r_b <= op_b;
        end
        S_UNPACK: begin
          r_sign        <= w_sign;
          r_exp         <= w_exp_clamped;
          r_prod        <= '0;
          r_mcand       <= P'(w_ma);
          r_mplier      <= w_mb;
          r_cnt         <= '0;
          r_sticky      <= 1'b0;
          r_stage_res   <= w_spec_res;
          r_stage_flags <= w_spec_flags;
        end
        S_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= {r_mcand[P-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[MAN_W:1]};
          r_cnt    <= r_cnt + CW'(1);
        end
        S_NORM: begin
          if (w_norm_rshift) begin
            r_sticky <= r_sticky | r_prod[0];
            r_prod   <= {1'b0, r_prod[P-1:1]};
            r_exp    <= w_exp_inc;
          end else if (w_norm_lshift) begin
            r_prod <= {r_prod[P-2:0], 1'b0};
            r_exp  <= w_exp_dec;
          end
        end
        S_ROUND: begin
          r_stage_res   <= w_rnd_res;
          r_stage_flags <= w_rnd_flags;
        end
        S_PACK: begin
          r_result <= r_stage_res;
          r_flags  <= r_stage_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;
endmodule

// File: tb/tb_fp_mul_param.sv
module tb_fp_mul_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv_s, ir_s, ov_s, or_s;
  logic [31:0] a_s, b_s, res_s;
  logic [3:0]  fl_s;
  logic        iv_h, ir_h, ov_h, or_h;
  logic [15:0] a_h, b_h, res_h;
  logic [3:0]  fl_h;

  fp_mul_param u_dut_s (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .op_a(a_s), .op_b(b_s),
    .out_valid(ov_s), .out_ready(or_s), .result(res_s), .flags(fl_s));

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) u_dut_h (
    .clk(clk), .rst(rst), .in_valid(iv_h), .in_ready(ir_h), .op_a(a_h), .op_b(b_h),
    .out_valid(ov_h), .out_ready(or_h), .result(res_h), .flags(fl_h));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, then a single shift to the target
  // precision with round-half-even on the discarded remainder.
  function automatic void model(input int ew, input int mw, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic [3:0] fl);
    longint unsigned emax, fmask, qbit, sa, sb, ea, eb, fa, fb, siga, sigb, p, sig, rem, half, rs;
    int bias, e, k, en, ee, sh;
    bit daz, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, tiny, inexact, rup;
    daz = 1'b0;
`ifdef FP_MUL_DAZ_EN
    daz = 1'b1;
`endif
    emax  = (64'd1 << ew) - 1;
    fmask = (64'd1 << mw) - 1;
    qbit  = 64'd1 << (mw - 1);
    bias  = (1 << (ew - 1)) - 1;
    sa = (64'(a) >> (ew + mw)) & 1;  sb = (64'(b) >> (ew + mw)) & 1;
    ea = (64'(a) >> mw) & emax;      eb = (64'(b) >> mw) & emax;
    fa = 64'(a) & fmask;             fb = 64'(b) & fmask;
    a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
    a_inf = (ea == emax) && (fa == 0);  b_inf = (eb == emax) && (fb == 0);
    a_zero = (ea == 0) && ((fa == 0) || daz);
    b_zero = (eb == 0) && ((fb == 0) || daz);
    rs = (sa ^ sb) << (ew + mw);
    fl = 4'b0000;
    res = 32'(rs);
    if (a_nan) begin
      res = 32'(64'(a) | qbit); fl[3] = ((fa & qbit) == 0);
    end else if (b_nan) begin
      res = 32'(64'(b) | qbit); fl[3] = ((fb & qbit) == 0);
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 32'((emax << mw) | qbit); fl = 4'b1000;
    end else if (a_inf || b_inf) begin
      res = 32'(rs | (emax << mw));
    end else if (a_zero || b_zero) begin
      res = 32'(rs);
    end else begin
      siga = (ea == 0) ? fa : (fa | (64'd1 << mw));
      sigb = (eb == 0) ? fb : (fb | (64'd1 << mw));
      p = siga * sigb;
      e = int'((ea == 0) ? 64'd1 : ea) + int'((eb == 0) ? 64'd1 : eb) - bias;
      k = 0;
      for (int i = 0; i < 64; i++) if (p[i]) k = i;
      en = e + k - 2*mw;
      tiny = (en < 1);
      if (daz && tiny) begin
        res = 32'(rs); fl = 4'b0011;
      end else begin
        if (!tiny) begin ee = en; sh = k - mw; end
        else       begin ee = 1;  sh = k - mw + 1 - en; end
        rup = 1'b0; rem = 0;
        if (sh <= 0) sig = p << (-sh);
        else if (sh >= 64) begin sig = 0; rem = p; end
        else begin
          sig  = p >> sh;
          rem  = p & ((64'd1 << sh) - 1);
          half = 64'd1 << (sh - 1);
          rup  = (rem > half) || ((rem == half) && sig[0]);
        end
        sig = sig + 64'(rup);
        if (sig == (64'd1 << (mw + 1))) begin sig = sig >> 1; ee++; end
        inexact = (rem != 0);
        if (ee >= int'(emax)) begin
          res = 32'(rs | (emax << mw)); fl = 4'b0101;
        end else begin
          res = 32'(rs | ((sig >= (64'd1 << mw)) ? (64'(ee) << mw) : 64'd0) | (sig & fmask));
          fl  = {2'b00, tiny && inexact, inexact};
        end
      end
    end
  endfunction

  function automatic logic [31:0] gen_op(input int ew, input int mw);
    longint unsigned emax, e, f, s;
    int c, bias;
    emax = (64'd1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    c = int'($urandom_range(0, 19));
    s = 64'($urandom_range(0, 1));
    if (c < 3)       e = 0;
    else if (c == 3) e = emax;
    else if (c < 10) e = 64'(bias - 3 + int'($urandom_range(0, 6)));
    else             e = 64'($urandom_range(1, 32'(emax - 1)));
    f = {$urandom, $urandom} & ((64'd1 << mw) - 1);
    if ($urandom_range(0, 7) == 0) f = 0;
    return 32'((s << (ew + mw)) | (e << mw) | f);
  endfunction

  function automatic logic get_ov(input bit sel); return sel ? ov_h : ov_s; endfunction
  function automatic logic get_ir(input bit sel); return sel ? ir_h : ir_s; endfunction
  function automatic logic [31:0] get_res(input bit sel);
    return sel ? {16'h0, res_h} : res_s;
  endfunction
  function automatic logic [3:0] get_fl(input bit sel); return sel ? fl_h : fl_s; endfunction

  task automatic drive_in(input bit sel, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin iv_h = v; a_h = a[15:0]; b_h = b[15:0]; end
    else     begin iv_s = v; a_s = a;       b_s = b;       end
  endtask

  task automatic set_or(input bit sel, input logic v);
    if (sel) or_h = v; else or_s = v;
  endtask

  // One operation; exp_lat==0 means only the latency bound is checked.
  task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef, input int exp_lat,
                        input int hold, input string name);
    int lat;
    bit done;
    int bound;
    bound = sel ? 3*10 + 8 : 3*23 + 8;
    @(negedge clk);
    check({name, " in_ready"}, 64'(get_ir(sel)), 64'd1);
    drive_in(sel, 1'b1, a, b);
    @(posedge clk);
    #1;
    drive_in(sel, 1'b0, $urandom, $urandom);   // operands must already be captured
    done = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_ov(sel)) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: out_valid not seen within 400 cycles", name);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    if (exp_lat > 0) check({name, " latency"}, 64'(lat), 64'(exp_lat));
    else             check({name, " latency_bound"}, 64'(lat >= 3 && lat <= bound), 64'd1);
    check({name, " result"}, 64'(get_res(sel)), 64'(er));
    check({name, " flags"},  64'(get_fl(sel)),  64'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s hold%0d", name, i),
            {26'h0, get_ov(sel), get_ir(sel), get_fl(sel), get_res(sel)},
            {26'h0, 1'b1, 1'b0, ef, er});
    end
    set_or(sel, 1'b1);
    @(posedge clk);
    #1;
    set_or(sel, 1'b0);
    check({name, " released"}, {62'h0, get_ov(sel), get_ir(sel)}, 64'd1);
    $display("op %s: a=0x%0h b=0x%0h result=0x%0h flags=%b latency=%0d",
             name, a, b, get_res(sel), get_fl(sel), lat);
  endtask

  typedef struct {
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    int seen;

    vt[0]  = '{0, 32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, 28, 10};
    vt[1]  = '{0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 3, 0};
    vt[2]  = '{0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 3, 0};
    vt[3]  = '{0, 32'h7F800001, 32'h3F800000, 32'h7FC00001, 4'b1000, 3, 0};
    vt[4]  = '{0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 28, 0};
`ifdef FP_MUL_DAZ_EN
    vt[5]  = '{0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 28, 0};
    vt[7]  = '{0, 32'h00000001, 32'h3F000000, 32'h00000000, 4'b0000, 3, 0};
`else
    vt[5]  = '{0, 32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000, 29, 0};
    vt[7]  = '{0, 32'h00000001, 32'h3F000000, 32'h00000000, 4'b0011, 29, 0};
`endif
    vt[6]  = '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28, 0};
    vt[8]  = '{0, 32'h7FC00000, 32'h7F800001, 32'h7FC00000, 4'b0000, 3, 0};
    vt[9]  = '{0, 32'h3F800000, 32'hFF800001, 32'hFFC00001, 4'b1000, 3, 0};
    vt[10] = '{0, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 3, 0};
    vt[11] = '{1, 32'h00003C00, 32'h00003C00, 32'h00003C00, 4'b0000, 15, 0};
    vt[12] = '{1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b0101, 15, 0};

    rst = 1'b1;
    drive_in(0, 1'b0, 32'h0, 32'h0);
    drive_in(1, 1'b0, 32'h0, 32'h0);
    or_s = 1'b0;
    or_h = 1'b0;
    #12;
    check("reset_s", {26'h0, ov_s, ir_s, fl_s, res_s}, {26'h0, 1'b0, 1'b1, 4'h0, 32'h0});
    check("reset_h", {42'h0, ov_h, ir_h, fl_h, res_h}, {42'h0, 1'b0, 1'b1, 4'h0, 16'h0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].res, vt[i].fl, vt[i].lat, vt[i].hold,
             $sformatf("vec%0d", i));

    // Reset while the significand multiply is in progress.
    @(negedge clk);
    drive_in(0, 1'b1, 32'h40400000, 32'h40000000);
    @(posedge clk);
    #1;
    drive_in(0, 1'b0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", {30'h0, ov_s, ir_s, res_s}, {30'h0, 1'b0, 1'b1, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ov_s) seen++;
    end
    check("rst_no_stale", 64'(seen), 64'd0);
    run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0, "after_rst");

    for (int i = 0; i < 200; i++) begin
      a = gen_op(8, 23);
      b = gen_op(8, 23);
      model(8, 23, a, b, er, ef);
      run_op(0, a, b, er, ef, 0, 0, $sformatf("rnd_s%0d", i));
    end
    for (int i = 0; i < 150; i++) begin
      a = 32'(gen_op(5, 10));
      b = 32'(gen_op(5, 10));
      model(5, 10, a, b, er, ef);
      run_op(1, a, b, er, ef, 0, 0, $sformatf("rnd_h%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
